// File: rtl/cnn_buf_pkg.sv
// Shared defaults and FSM encoding for the CNN feature-map ping-pong buffers.
// No logic; types and constants only.
// Backpressure: n/a.
package cnn_buf_pkg;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 16;
    localparam int FRAME_WORDS = 4096;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } wr_state_t;

endpackage

// File: rtl/buffer_write_ctrl_ptr.sv
// Frame write pointer: counts accepted words and wraps at the frame boundary.
// Latency: pointer advances at the edge a word is accepted; last_word is combinational.
// Backpressure: none, advances only when told to.
module buffer_write_ctrl_ptr #(
    parameter int ADDR_W      = cnn_buf_pkg::ADDR_W,
    parameter int FRAME_WORDS = cnn_buf_pkg::FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              last_word
);

    assign last_word = (wr_ptr == ADDR_W'(FRAME_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (adv) begin
            wr_ptr <= last_word ? '0 : wr_ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/buffer_write_ctrl.sv
// Ping-pong write controller filling two BRAM banks one frame at a time.
// Latency: write port registered one cycle after acceptance; bank_full/frame_done one cycle later.
// Backpressure: in_ready drops when the next bank still holds an unread frame.
module buffer_write_ctrl #(
    parameter int DATA_W      = cnn_buf_pkg::DATA_W,
    parameter int ADDR_W      = cnn_buf_pkg::ADDR_W,
    parameter int FRAME_WORDS = cnn_buf_pkg::FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        bank_release,
    output logic [1:0]        ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [1:0]        bank_full,
    output logic              frame_done,
    output logic              active_bank
);

    import cnn_buf_pkg::*;

    wr_state_t         state, state_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic              last_word;
    logic              xfer;
    logic              frame_end;
    logic              pend;
    logic              pend_bank;
    logic [1:0]        occ;

    assign xfer      = in_valid & in_ready;
    assign frame_end = xfer & last_word;

    buffer_write_ctrl_ptr #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .adv       (xfer),
        .wr_ptr    (wr_ptr),
        .last_word (last_word)
    );

    // Bank occupancy after this edge; a frame finished last edge counts as full
    // already so FRAME_WORDS=1 cannot overwrite a bank before its flag lands.
    always_comb begin
        occ = bank_full & ~bank_release;
        if (pend) begin
            occ[pend_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            FILL:    if (frame_end && occ[~active_bank]) state_n = STALL;
            STALL:   if (!occ[active_bank])              state_n = FILL;
            default: state_n = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state == FILL) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena         <= 2'b00;
            wea         <= 1'b0;
            addra       <= '0;
            dina        <= '0;
            bank_full   <= 2'b00;
            frame_done  <= 1'b0;
            active_bank <= 1'b0;
            pend        <= 1'b0;
            pend_bank   <= 1'b0;
        end else begin
            ena        <= xfer ? (active_bank ? 2'b10 : 2'b01) : 2'b00;
            wea        <= xfer;
            bank_full  <= occ;
            frame_done <= pend;
            pend       <= frame_end;
            if (xfer) begin
                addra <= wr_ptr;
                dina  <= in_data;
            end
            if (frame_end) begin
                pend_bank   <= active_bank;
                active_bank <= ~active_bank;
            end
        end
    end

endmodule

// File: tb/tb_buffer_write_ctrl.sv
// Self-checking bench for buffer_write_ctrl against a frame-level reference model.
// Directed fill/stall/release sequences, then randomized traffic with a mid-frame reset.
module tb_buffer_write_ctrl;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int FW = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    bank_release;
    logic [1:0]    ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic [1:0]    bank_full;
    logic          frame_done;
    logic          active_bank;

    buffer_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FRAME_WORDS(FW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bank_release (bank_release),
        .ena          (ena),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .bank_full    (bank_full),
        .frame_done   (frame_done),
        .active_bank  (active_bank)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words into the current frame, frames completed since reset,
    // the set of full banks and a frame awaiting its full flag.
    int       m_words;
    int       m_frames;
    bit [1:0] m_full;
    bit       m_pend;
    bit       m_pend_b;
    bit       m_fd;
    bit       m_ready;
    bit [1:0] e_ena;
    bit       e_wea;
    int       e_addr;
    int       e_din;
    int       seq;
    int       fd_count;

    function automatic bit cur_bank();
        return bit'(m_frames % 2);
    endfunction

    task automatic model_reset();
        m_words = 0; m_frames = 0; m_full = 2'b00; m_pend = 0; m_pend_b = 0;
        m_fd = 0; m_ready = 1; e_ena = 2'b00; e_wea = 0;
    endtask

    task automatic model_update(input bit v, input int d, input bit [1:0] rel);
        bit       xfer;
        bit [1:0] nfull;
        bit       b;
        xfer  = v && m_ready;
        nfull = m_full & ~rel;
        m_fd  = m_pend;
        if (m_pend) nfull[m_pend_b] = 1'b1;
        m_pend = 0;
        if (xfer) begin
            b      = cur_bank();
            e_ena  = b ? 2'b10 : 2'b01;
            e_wea  = 1;
            e_addr = m_words;
            e_din  = d;
            seq++;
            m_words++;
            if (m_words == FW) begin
                m_words  = 0;
                m_pend   = 1;
                m_pend_b = b;
                m_frames++;
            end
        end else begin
            e_ena = 2'b00;
            e_wea = 0;
        end
        m_full  = nfull;
        b       = cur_bank();
        m_ready = !(m_full[b] || (m_pend && m_pend_b == b));
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, m_ready);
        chk("ena", ena, e_ena);
        chk("wea", wea, e_wea);
        if (e_wea) begin
            chk("addra", addra, e_addr);
            chk("dina", dina, e_din);
        end
        chk("bank_full", bank_full, m_full);
        chk("frame_done", frame_done, m_fd);
        chk("active_bank", active_bank, cur_bank());
        if (frame_done) fd_count++;
    endtask

    task automatic step(input bit v, input bit [1:0] rel);
        int d;
        d            = seq % 256;
        in_valid     = v;
        in_data      = DW'(d);
        bank_release = rel;
        model_update(v, d, rel);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_vals();
        chk("rst_ena", ena, 0);
        chk("rst_wea", wea, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        chk("rst_bank_full", bank_full, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_active_bank", active_bank, 0);
        chk("rst_in_ready", in_ready, 0);
    endtask

    task automatic rand_step();
        bit [1:0] rel;
        rel[0] = ($urandom_range(0, 799) == 0);
        rel[1] = ($urandom_range(0, 799) == 0);
        step(bit'($urandom_range(0, 1)), rel);
    endtask

    initial begin
        int guard;
        seq = 0; fd_count = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; bank_release = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);

        // Frame 1 into bank 0, plus the first word of frame 2.
        for (int i = 0; i < FW + 1; i++) step(1, 2'b00);
        chk("f1_full", bank_full, 2'b01);
        chk("f1_bank", active_bank, 1);
        chk("f1_ready", in_ready, 1);
        chk("f1_fd_count", fd_count, 1);

        // Finish frame 2 with no release: both banks full, stream stalls.
        for (int i = FW + 1; i < 2 * FW; i++) step(1, 2'b00);
        repeat (6) step(1, 2'b00);
        chk("stall_full", bank_full, 2'b11);
        chk("stall_ready", in_ready, 0);
        chk("stall_ena", ena, 0);

        step(1, 2'b01);
        chk("rel0_ready", in_ready, 1);
        step(1, 2'b00);
        chk("rel0_ena", ena, 2'b01);
        chk("rel0_addr", addra, 0);

        // Frame 3 finishes in the same cycle bank 1 is released.
        guard = 0;
        while (!(m_words == FW - 1 && m_ready) && guard < 2 * FW) begin
            step(1, 2'b00);
            guard++;
        end
        chk("f3_reached", guard < 2 * FW, 1);
        step(1, 2'b10);
        chk("f3_no_stall", in_ready, 1);
        step(1, 2'b00);
        chk("f4_ena", ena, 2'b10);
        chk("f4_addr", addra, 0);
        repeat (20) step(1, 2'b00);

        // Release of bank 1 while it is being filled and not full is ignored.
        step(1, 2'b10);
        chk("bogus_rel_full", bank_full, 2'b01);
        repeat (10) step(1, 2'b00);

        for (int i = 0; i < 3000; i++) rand_step();

        guard = 0;
        while (m_words == 0 && guard < 4000) begin
            rand_step();
            guard++;
        end
        chk("midframe_reached", m_words != 0, 1);
        rst = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rerst_ready", in_ready, 1);
        step(1, 2'b00);
        chk("rerst_ena", ena, 2'b01);
        chk("rerst_addr", addra, 0);
        for (int i = 0; i < 3000; i++) rand_step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/buffer_write_ctrl.md
# buffer_write_ctrl

Ping-pong write controller that sits directly upstream of the paired `buffer_memory_blocks` feature-map banks. It accepts a valid/ready pixel stream and generates port-A `ena`/`wea`/`addra`/`dina` for bank 0 and bank 1. It fills the banks alternately, one frame per bank, and flags each full bank to the downstream reader. It stalls the stream when both banks hold unread frames, and resumes when the reader releases one.

## Interface
- `DATA_W`, 8, pixel width; matches the bank `dina` width.
- `ADDR_W`, 16, bank address width.
- `FRAME_WORDS`, 4096, words per frame; legal range 1..2^ADDR_W.

Ports:
- `clk`  in  1  single clock for all logic and both bank port-A clocks.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  DATA_W  pixel.
- `in_valid`  in  1  pixel present.
- `in_ready`  out  1  controller accepts a pixel this cycle.
- `bank_release`  in  2  one-cycle pulse per bit; reader has finished bank b.
- `ena`  out  2  port-A enable, one bit per bank (bit b drives bank b `ena`).
- `wea`  out  1  write enable, shared by both banks.
- `addra`  out  ADDR_W  write address, shared by both banks.
- `dina`  out  DATA_W  write data, shared by both banks.
- `bank_full`  out  2  bank b holds a complete, unreleased frame.
- `frame_done`  out  1  one-cycle pulse when a bank becomes full.
- `active_bank`  out  1  bank currently being filled.

## Operation
- States:
  - FILL: `in_ready`=1.
  - STALL: `in_ready`=0; next bank is still full.
- Handshake: a transfer occurs when `in_valid` & `in_ready` are both high at a rising edge. `in_data` is don't-care otherwise.
- Each transfer writes to bank `active_bank` at address `wr_ptr`, then increments `wr_ptr`.
- Last word of a frame (`wr_ptr` = FRAME_WORDS-1 on transfer):
  - `wr_ptr` wraps to 0.
  - `active_bank` toggles.
  - If the new bank is full and is not being released this same cycle, go to STALL. Otherwise stay in FILL.
- STALL -> FILL on the edge where `bank_full[active_bank]` clears.
- `bank_release[b]`:
  - Clears `bank_full[b]`.
  - A release of a bank that is not full is ignored, including a release of the bank currently being filled.
- Simultaneous release of bank b and the last write into the other bank: no stall. The next frame goes into bank b with `in_ready` held high.
- FRAME_WORDS=1: every transfer completes a frame.
- Mid-frame reset: all progress is discarded. There is no partial-frame recovery.

## Timing
- Reset values:
  - `ena`=0, `wea`=0, `addra`=0, `dina`=0.
  - `bank_full`=0, `frame_done`=0, `active_bank`=0.
  - `in_ready`=0 while `rst` is high.
  - `in_ready`=1 in the first cycle after `rst` deasserts (FILL, bank 0, `wr_ptr` 0).
- Write outputs are registered. A transfer sampled at edge k drives `ena[active_bank]`=1, `wea`=1, `addra`, `dina` during cycle k..k+1, and the BRAM commits at edge k+1. With no transfer at edge k, `ena` and `wea` are 0 in the next cycle.
- Full-bank signalling for the last transfer at edge k:
  - `bank_full[b]` rises at edge k+1, after the BRAM write has committed.
  - `frame_done` is high for cycle k+1..k+2 only.
- Stall entry for the last transfer at edge k:
  - `in_ready` is low from edge k onward (registered state).
  - Maximum throughput is one word per cycle, with no bubble between frames.
- A release at edge r clears `bank_full` at edge r. `in_ready` is high in cycle r..r+1.
- `in_ready` does not depend combinationally on `in_valid`.

## Structure
- Shared package `cnn_buf_pkg`: `DATA_W`, `ADDR_W`, `FRAME_WORDS` defaults, and a state enum with values FILL and STALL.
- No sub-module is required. An optional `buffer_write_ctrl_ptr` holds `wr_ptr` plus the wrap and last-word flag.
- The instantiating top connects `ena[b]` to bank b, and `wea`, `addra`, `dina` to both banks.

## Test plan
- Reset, then stream 4096 words 0..255 repeating with `in_valid` held high:
  - bank 0 is written at addresses 0..4095;
  - `frame_done` pulses once, one cycle after the last write;
  - `bank_full`=01, `active_bank`=1, `in_ready` stays high.
- Stream 8192 words with no release:
  - `bank_full`=11;
  - `in_ready` is low from the cycle after word 8191 is accepted;
  - no further `ena` activity.
- From the stalled state, pulse `bank_release`=01:
  - `in_ready` goes high the next cycle;
  - the next word is written to bank 0, address 0.
- Pulse `bank_release[1]` in the same cycle as the final word of frame 3 (bank 0), with bank 1 full: there is no stall cycle, and frame 4 starts in bank 1 at address 0.
- Toggle `in_valid` randomly and assert `rst` midway through a frame:
  - all outputs return to their reset values immediately;
  - after reset, writing restarts in bank 0 at address 0.
- Pulse `bank_release`=10 while bank 1 is not full: `bank_full` is unchanged and there is no effect on writes.
